aes_sub_bytes_seq: RTL and testbench

- Multi-cycle AES SubBytes engine for a full 128-bit state.
- Uses LANES parallel S-box lanes. Each lane is a gf_inv_8 instance followed directly by the FIPS-197 affine transform.
- Sits between AddRoundKey and ShiftRows in the round datapath.
- Trades area for latency by iterating over the 16 state bytes.

---
 rtl/aes_sub_bytes_seq_if.sv | 25 ++
 rtl/aes_sub_bytes_seq.sv | 167 ++++++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sub_bytes_seq_if.sv
// aes_sub_bytes_seq_if
//   Handshake/bus bundle for the iterative AES SubBytes engine.
//   master : state producer/consumer side (drives in_valid, in_state, in_inv, out_ready)
//   slave  : the engine (drives in_ready, out_valid, out_state, busy)
//   in_state/out_state byte 0 = [127:120], byte 15 = [7:0].
interface aes_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq
//   Multi-cycle AES SubBytes over a full 128-bit state, LANES bytes per cycle
//   (NCYC = 16/LANES cycles per state). Each lane is a GF(2^8) inverter
//   followed by the forward affine transform.
//   Optional build macro AES_INV_SBOX_EN adds a per-lane inverse S-box path
//   selected by in_inv latched at acceptance; without it in_inv is ignored.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : aes_sub_bytes_seq_if.slave (in_valid/in_ready/in_state/in_inv,
//          out_valid/out_ready/out_state, busy)

// Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1; 0 maps to 0.
module gf_inv_8 (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) r = r ^ t;
            t = xtime(t);
        end
        return r;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128, which is a^-1 and gives 0 for 0.
    function automatic logic [7:0] gf_pow254(input logic [7:0] v);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = v;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    assign y = gf_pow254(a);
endmodule

module aes_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    aes_sub_bytes_seq_if.slave bus
);
    localparam int NCYC  = 16 / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $fatal(1, "aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t              fsm_p0, fsm_nxt;
    logic [0:15][7:0]  dat_p0;   // element j is state byte j
    logic [0:15][7:0]  dat_nxt;
    logic [CNT_W-1:0]  cnt_p0;
    logic [7:0]        lane_out [LANES];
    logic              accept;

    // rotl(x,k) bit i = x[i-k], so the XOR of rotations 0..4 is the FIPS affine matrix
    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_INV_SBOX_EN
    logic inv_p0;

    // y_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ 0x05, i.e. rotations by 6, 3 and 1
    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)         inv_p0 <= 1'b0;
        else if (accept) inv_p0 <= bus.in_inv;
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = bus.in_inv;
`endif

    assign accept = (fsm_p0 == IDLE) && bus.in_valid;

    // Lane l works on byte cnt*LANES + l of the held state.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] b;
        logic [7:0] g_in;
        logic [7:0] g_out;

        assign b = dat_p0[4'(int'(cnt_p0) * LANES + l)];
`ifdef AES_INV_SBOX_EN
        assign g_in        = inv_p0 ? aff_inv(b) : b;
        gf_inv_8 u_inv (.a(g_in), .y(g_out));
        assign lane_out[l] = inv_p0 ? g_out : aff_fwd(g_out);
`else
        assign g_in        = b;
        gf_inv_8 u_inv (.a(g_in), .y(g_out));
        assign lane_out[l] = aff_fwd(g_out);
`endif
    end

    always_comb begin
        dat_nxt = dat_p0;
        for (int l = 0; l < LANES; l++) begin
            dat_nxt[4'(int'(cnt_p0) * LANES + l)] = lane_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fsm_p0 <= IDLE;
        else     fsm_p0 <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt       = fsm_p0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (fsm_p0)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) fsm_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt_p0 == CNT_LAST) fsm_nxt = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // state register: loaded on accept, one lane group rewritten per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_p0 <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            dat_p0 <= bus.in_state;
            cnt_p0 <= '0;
        end else if (fsm_p0 == RUN) begin
            dat_p0 <= dat_nxt;
            cnt_p0 <= (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + CNT_W'(1);
        end
    end

    assign bus.out_state = dat_p0;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: a byte-level S-box model built from GF(2^8)
// arithmetic, a per-cycle compare process and directed literal vectors.
module tb_aes_sub_bytes_seq;
    localparam int LANES = 4;
    localparam int NCYC  = 16 / LANES;

    logic clk;
    logic rst;
    aes_sub_bytes_seq_if bus ();

    aes_sub_bytes_seq #(.LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endfunction

    // carry-less product then reduction mod 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic void build_tables();
        logic [7:0] x;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int v = 0; v < 256; v++) begin
            x = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) x = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8] ^ c[i];
            sbox[v] = s;
        end
        for (int v = 0; v < 256; v++) isbox[sbox[v]] = 8'(v);
    endfunction

    // first n bytes substituted, rest untouched
    function automatic logic [127:0] subst(input logic [127:0] s, input int n, input logic inv);
        logic [127:0] r;
        r = s;
        for (int j = 0; j < n; j++)
            r[127 - 8 * j -: 8] = inv ? isbox[s[127 - 8 * j -: 8]] : sbox[s[127 - 8 * j -: 8]];
        return r;
    endfunction

    // behavioural model: job present, chunks of LANES bytes completed, visible image
    logic         m_job    = 1'b0;
    int           m_chunks = 0;
    logic [127:0] m_orig   = '0;
    logic [127:0] m_img    = '0;
    logic         m_inv    = 1'b0;
    logic         m_on     = 1'b0;

    always @(negedge clk) begin
        if (m_on) begin
            chk("in_ready",  128'(bus.in_ready),  128'(!m_job));
            chk("out_valid", 128'(bus.out_valid), 128'(m_job && m_chunks == NCYC));
            chk("busy",      128'(bus.busy),      128'(m_job));
            chk("out_state", bus.out_state,       m_img);
            if (rst) begin
                m_job = 1'b0; m_chunks = 0; m_img = '0; m_inv = 1'b0;
            end else if (!m_job) begin
                if (bus.in_valid) begin
                    m_job = 1'b1; m_chunks = 0; m_orig = bus.in_state; m_img = bus.in_state;
`ifdef AES_INV_SBOX_EN
                    m_inv = bus.in_inv;
`else
                    m_inv = 1'b0;
`endif
                end
            end else if (m_chunks < NCYC) begin
                m_chunks++;
                m_img = subst(m_orig, m_chunks * LANES, m_inv);
            end else if (bus.out_ready) begin
                m_job = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one state, measure latency, check literal result, then drain.
    task automatic run_vec(input string nm, input logic [127:0] s, input logic inv, input logic [127:0] exp);
        int cyc;
        chk({nm, "_rdy"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1; bus.in_state = s; bus.in_inv = inv; bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0; bus.in_state = '0;
        cyc = 0;
        while (!bus.out_valid && cyc < 64) begin
            step();
            cyc++;
        end
        chk({nm, "_lat"}, 128'(cyc), 128'(NCYC));
        chk({nm, "_res"}, bus.out_state, exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({nm, "_vld0"}, 128'(bus.out_valid), 128'(0));
        chk({nm, "_rdy1"}, 128'(bus.in_ready),  128'(1));
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        int seen;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_state = FIPS_IN; bus.in_inv = 1'b0; bus.out_ready = 1'b0;
        build_tables();
        m_on = 1'b1;

        chk("model_s00", 128'(sbox[8'h00]), 128'(8'h63));
        chk("model_s01", 128'(sbox[8'h01]), 128'(8'h7c));
        chk("model_s10", 128'(sbox[8'h10]), 128'(8'hca));
        chk("model_s74", 128'(sbox[8'h74]), 128'(8'h92));
        chk("model_s47", 128'(sbox[8'h47]), 128'(8'ha0));
        chk("model_s53", 128'(sbox[8'h53]), 128'(8'hed));
        chk("model_fips", subst(FIPS_IN, 16, 1'b0), FIPS_OUT);

        // reset held two cycles with in_valid high
        step();
        step();
        chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy",      128'(bus.busy),      128'(0));
        chk("rst_out_state", bus.out_state,       '0);
        rst = 1'b0; bus.in_valid = 1'b0;
        step();

        run_vec("fips",   FIPS_IN, 1'b0, FIPS_OUT);
        run_vec("all00",  {16{8'h00}}, 1'b0, {16{8'h63}});
        run_vec("all01",  {16{8'h01}}, 1'b0, {16{8'h7c}});
        run_vec("mix",    {4{32'h10744753}}, 1'b0, {4{32'hca92a0ed}});
`ifdef AES_INV_SBOX_EN
        run_vec("inv63",  {16{8'h63}}, 1'b1, {16{8'h00}});
        run_vec("invED",  {16{8'hed}}, 1'b1, {16{8'h53}});
        run_vec("invfips", FIPS_OUT, 1'b1, FIPS_IN);
`else
        run_vec("noinv",  {16{8'h00}}, 1'b1, {16{8'h63}});
`endif

        // backpressure: result held while out_ready low, second state refused
        bus.in_valid = 1'b1; bus.in_state = FIPS_IN; bus.in_inv = 1'b0;
        step();
        bus.in_state = {16{8'h01}};
        seen = 0;
        while (!bus.out_valid && seen < 64) begin
            step();
            seen++;
        end
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold",  bus.out_state,        FIPS_OUT);
            chk("bp_ready", 128'(bus.in_ready),   128'(0));
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_vld0", 128'(bus.out_valid), 128'(0));
        chk("bp_rdy1", 128'(bus.in_ready),  128'(1));
        chk("bp_keep", bus.out_state,       FIPS_OUT);

        // reset when the byte counter has reached 2
        bus.in_valid = 1'b1; bus.in_state = FIPS_IN;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_vld",   128'(bus.out_valid), 128'(0));
        chk("abort_state", bus.out_state,       '0);
        chk("abort_rdy",   128'(bus.in_ready),  128'(1));
        bus.out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("abort_noout", 128'(seen), 128'(0));

        // randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_state  = {$urandom, $urandom, $urandom, $urandom};
            bus.in_inv    = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 2 * NCYC + 4; k++) step();

        m_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
